aucohl_fifo_th: RTL and testbench

Parametrised synchronous FIFO with a full-range occupancy count, a programmable level threshold, and sticky overrun/underrun error flags. It is the next-generation buffer for peripheral data paths (UART/SPI/I2C RX/TX) in the AUCOHL IP library, where software needs threshold-based interrupts and error reporting. It also defines a fixed behaviour for simultaneous read/write at the empty and full boundaries.

---
 rtl/aucohl_fifo_th.sv | 126 ++++++++++++
 tb/tb_aucohl_fifo_th.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/aucohl_fifo_th.sv
// ---------------------------------------------------------------------------
// aucohl_fifo_th
//   Synchronous show-ahead FIFO with a full-range occupancy count, a
//   programmable level threshold and sticky overrun/underrun flags.
//   Intended for peripheral RX/TX buffering where software polls or takes
//   interrupts on the level threshold and on request errors.
//
// Parameters
//   DW        data width in bits
//   AW        address width; depth is 2**AW entries (AW >= 1)
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset (control state only)
//   flush      synchronous clear of pointers and level
//   wr, wdata  write request and data
//   rd         pop request for the entry shown on rdata
//   rdata      head-of-queue data (undefined when empty)
//   empty      level == 0
//   full       level == 2**AW
//   level      stored entry count, 0..2**AW
//   threshold  compare value for above_th
//   above_th   level > threshold (unsigned)
//   clr_flags  clears overrun and underrun
//   overrun    sticky: a write was rejected
//   underrun   sticky: a read was rejected
// ---------------------------------------------------------------------------
module aucohl_fifo_th #(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          wr,
  input  logic [DW-1:0] wdata,
  input  logic          rd,
  output logic [DW-1:0] rdata,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   level,
  input  logic [AW:0]   threshold,
  output logic          above_th,
  input  logic          clr_flags,
  output logic          overrun,
  output logic          underrun
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] DEPTH_L = (AW + 1)'(DEPTH);
  localparam logic [AW:0] ONE_L   = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] w_ptr;
  logic [AW-1:0] r_ptr;
  logic [AW:0]   level_reg;
  logic          overrun_reg;
  logic          underrun_reg;

  logic wr_ok;
  logic rd_ok;
  logic wr_rej;
  logic rd_rej;

  // Status is decoded from the level count so that w_ptr == r_ptr is never
  // ambiguous between empty and full.
  assign empty = (level_reg == '0);
  assign full  = (level_reg == DEPTH_L);

  // A write into a full FIFO is still accepted when a pop frees the head
  // slot in the same cycle. A read of an empty FIFO is always rejected, even
  // with a concurrent write, because the new data is not yet at the head.
  assign wr_ok  = wr & (~full | rd);
  assign rd_ok  = rd & ~empty;
  assign wr_rej = wr & ~wr_ok;
  assign rd_rej = rd & empty;

  // Storage: data only, never reset. Writes are suppressed under reset and
  // flush so that a discarded request leaves no trace.
  always_ff @(posedge clk) begin
    if (rst_n && !flush && wr_ok) begin
      mem[w_ptr] <= wdata;
    end
  end

  // Control state: pointers, level and sticky flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      w_ptr        <= '0;
      r_ptr        <= '0;
      level_reg    <= '0;
      overrun_reg  <= 1'b0;
      underrun_reg <= 1'b0;
    end else begin
      if (flush) begin
        w_ptr     <= '0;
        r_ptr     <= '0;
        level_reg <= '0;
      end else begin
        if (wr_ok) begin
          w_ptr <= w_ptr + PTR_ONE;
        end
        if (rd_ok) begin
          r_ptr <= r_ptr + PTR_ONE;
        end
        case ({wr_ok, rd_ok})
          2'b10:   level_reg <= level_reg + ONE_L;
          2'b01:   level_reg <= level_reg - ONE_L;
          default: level_reg <= level_reg;
        endcase
      end
      // A set in the same cycle wins over clr_flags; flush never sets a flag
      // because its concurrent requests are discarded, not rejected.
      overrun_reg  <= (wr_rej & ~flush) | (overrun_reg  & ~clr_flags);
      underrun_reg <= (rd_rej & ~flush) | (underrun_reg & ~clr_flags);
    end
  end

  assign rdata    = mem[r_ptr];
  assign level    = level_reg;
  assign above_th = (level_reg > threshold);
  assign overrun  = overrun_reg;
  assign underrun = underrun_reg;

endmodule

// File: tb/tb_aucohl_fifo_th.sv
module tb_aucohl_fifo_th;

  localparam int DW = 8;
  localparam int AW = 2;

  logic          clk;
  logic          rst_n;
  logic          flush;
  logic          wr;
  logic [DW-1:0] wdata;
  logic          rd;
  logic [DW-1:0] rdata;
  logic          empty;
  logic          full;
  logic [AW:0]   level;
  logic [AW:0]   threshold;
  logic          above_th;
  logic          clr_flags;
  logic          overrun;
  logic          underrun;

  int checks;
  int failures;

  aucohl_fifo_th #(.DW(DW), .AW(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .wr        (wr),
    .wdata     (wdata),
    .rd        (rd),
    .rdata     (rdata),
    .empty     (empty),
    .full      (full),
    .level     (level),
    .threshold (threshold),
    .above_th  (above_th),
    .clr_flags (clr_flags),
    .overrun   (overrun),
    .underrun  (underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit
  // after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr = 1'b0; rd = 1'b0; flush = 1'b0; clr_flags = 1'b0;
  endtask

  task automatic do_write(input logic [DW-1:0] d);
    idle(); wr = 1'b1; wdata = d;
    step();
    idle();
  endtask

  task automatic do_read();
    idle(); rd = 1'b1;
    step();
    idle();
  endtask

  logic [DW-1:0] fill_vals [4];
  logic [DW-1:0] drain_exp [4];

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    wdata = '0;
    threshold = 3'd2;
    idle();
    step();
    step();

    // Reset values
    check("rst_level",    32'(level),    32'd0);
    check("rst_empty",    32'(empty),    32'd1);
    check("rst_full",     32'(full),     32'd0);
    check("rst_above",    32'(above_th), 32'd0);
    check("rst_overrun",  32'(overrun),  32'd0);
    check("rst_underrun", 32'(underrun), 32'd0);
    rst_n = 1'b1;
    step();
    check("post_rst_level", 32'(level), 32'd0);

    // Fill with threshold = 2: above_th 0,0,0,1 at levels 0..3
    fill_vals[0] = 8'h11; fill_vals[1] = 8'h22;
    fill_vals[2] = 8'h33; fill_vals[3] = 8'h44;
    check("th_l0", 32'(above_th), 32'd0);
    for (int i = 0; i < 4; i++) begin
      do_write(fill_vals[i]);
      check($sformatf("fill_level%0d", i), 32'(level), 32'(i + 1));
      check($sformatf("fill_above%0d", i), 32'(above_th), (i + 1 > 2) ? 32'd1 : 32'd0);
    end
    check("fill_full",  32'(full),  32'd1);
    check("fill_empty", 32'(empty), 32'd0);
    check("fill_head",  32'(rdata), 32'h11);

    // Fifth write rejected
    do_write(8'h55);
    check("ovr_set",   32'(overrun), 32'd1);
    check("ovr_level", 32'(level),   32'd4);
    check("ovr_head",  32'(rdata),   32'h11);

    // Threshold = 4 at level 4 -> 0
    threshold = 3'd4;
    #1;
    check("th4_full", 32'(above_th), 32'd0);

    // clr_flags with concurrent rejected write: set wins
    idle(); wr = 1'b1; wdata = 8'h66; clr_flags = 1'b1;
    step();
    idle();
    check("clr_vs_set", 32'(overrun), 32'd1);
    check("clr_vs_set_level", 32'(level), 32'd4);
    // plain clr_flags
    clr_flags = 1'b1;
    step();
    idle();
    check("clr_ovr", 32'(overrun), 32'd0);

    // Drain in order
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drain_data%0d", i), 32'(rdata), 32'(fill_vals[i]));
      do_read();
      check($sformatf("drain_level%0d", i), 32'(level), 32'(3 - i));
    end
    check("drain_empty",    32'(empty),    32'd1);
    check("drain_underrun", 32'(underrun), 32'd0);

    // Empty + rd & wr: write accepted, read rejected
    idle(); rd = 1'b1; wr = 1'b1; wdata = 8'hA5;
    step();
    idle();
    check("erw_level",    32'(level),    32'd1);
    check("erw_underrun", 32'(underrun), 32'd1);
    check("erw_rdata",    32'(rdata),    32'hA5);
    // pop with clr_flags: no rejection, flag clears
    rd = 1'b1; clr_flags = 1'b1;
    step();
    idle();
    check("erw_pop_level", 32'(level),    32'd0);
    check("erw_clr_udr",   32'(underrun), 32'd0);

    // Full + rd & wr: pop head, append
    for (int i = 0; i < 4; i++) do_write(8'(i + 1));
    check("frw_pre_full", 32'(full), 32'd1);
    idle(); rd = 1'b1; wr = 1'b1; wdata = 8'h5A;
    step();
    idle();
    check("frw_level",   32'(level),   32'd4);
    check("frw_overrun", 32'(overrun), 32'd0);
    check("frw_full",    32'(full),    32'd1);
    drain_exp[0] = 8'h02; drain_exp[1] = 8'h03;
    drain_exp[2] = 8'h04; drain_exp[3] = 8'h5A;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("frw_data%0d", i), 32'(rdata), 32'(drain_exp[i]));
      do_read();
    end
    check("frw_empty", 32'(empty), 32'd1);

    // Flush keeps overrun
    for (int i = 0; i < 5; i++) do_write(8'h30 + 8'(i));
    check("fl_pre_ovr", 32'(overrun), 32'd1);
    flush = 1'b1;
    step();
    idle();
    check("fl_level",   32'(level),   32'd0);
    check("fl_empty",   32'(empty),   32'd1);
    check("fl_overrun", 32'(overrun), 32'd1);
    clr_flags = 1'b1;
    step();
    idle();
    check("fl_clr", 32'(overrun), 32'd0);

    // level 3, flush & wr: no write, no flag
    for (int i = 0; i < 3; i++) do_write(8'h40 + 8'(i));
    check("flw_pre_level", 32'(level), 32'd3);
    flush = 1'b1; wr = 1'b1; wdata = 8'hEE; rd = 1'b1;
    step();
    idle();
    check("flw_level",    32'(level),    32'd0);
    check("flw_overrun",  32'(overrun),  32'd0);
    check("flw_underrun", 32'(underrun), 32'd0);
    do_write(8'h77);
    check("flw_next_data",  32'(rdata), 32'h77);
    check("flw_next_level", 32'(level), 32'd1);
    do_read();

    // Underrun from rd on empty, then reset mid-stream at level 3
    do_read();
    check("udr_set", 32'(underrun), 32'd1);
    check("udr_level", 32'(level), 32'd0);
    threshold = 3'd0;
    for (int i = 0; i < 3; i++) do_write(8'h50 + 8'(i));
    check("mrst_pre_level", 32'(level),    32'd3);
    check("mrst_pre_above", 32'(above_th), 32'd1);
    rst_n = 1'b0; wr = 1'b1; wdata = 8'hBB;
    step();
    idle();
    check("mrst_level",    32'(level),    32'd0);
    check("mrst_empty",    32'(empty),    32'd1);
    check("mrst_full",     32'(full),     32'd0);
    check("mrst_above",    32'(above_th), 32'd0);
    check("mrst_overrun",  32'(overrun),  32'd0);
    check("mrst_underrun", 32'(underrun), 32'd0);
    rst_n = 1'b1;
    step();

    // Wrap: 10 write-then-read pairs
    threshold = 3'd2;
    for (int i = 0; i < 10; i++) begin
      do_write(8'(i));
      check($sformatf("wrap_lvl1_%0d", i), 32'(level), 32'd1);
      check($sformatf("wrap_data%0d", i), 32'(rdata), 32'(i));
      do_read();
      check($sformatf("wrap_lvl0_%0d", i), 32'(level), 32'd0);
    end
    check("wrap_flags", {30'd0, overrun, underrun}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
